inst_fetch_buffer: RTL and testbench



---
 rtl/inst_fetch_buffer.sv | 137 +++++++++++++
 tb/tb_inst_fetch_buffer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_buffer.sv
// Instruction queue between the instruction fetch port and decode; drops returns that belong to flushed requests.
// Optional build macro INST_BUF_BYPASS_EN forwards a return straight to decode when the queue is empty and decode pops.
module inst_fetch_buffer #(
  parameter int DEPTH   = 4,
  parameter int OST_MAX = 3
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        flush,
  input  logic        req_accept,
  input  logic        data_ok,
  input  logic [31:0] push_pc,
  input  logic [31:0] push_inst,
  input  logic        push_adel,
  output logic        can_issue,
  input  logic        pop,
  output logic        out_valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  output logic        out_adel,
  output logic [5:0]  out_op,
  output logic [4:0]  out_rs,
  output logic [4:0]  out_rt,
  output logic [5:0]  out_funct
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int OST_W = (OST_MAX < 2) ? 1 : $clog2(OST_MAX + 1);
  localparam int SUM_W = CNT_W + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        adel;
  } entry_t;

  logic [PTR_W-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [OST_W-1:0] ost_q, ost_d, discard_q, discard_d;
  logic             ovf_err_q, ovf_err_d;
  entry_t           mem_q [DEPTH];

  entry_t     push_entry, out_entry;
  logic       full, stored_valid, accept_ret, bypass_hit;
  logic       pop_en, push_en, ovf, wr_en;
  logic [SUM_W-1:0] occupancy;

  assign push_entry   = '{pc: push_pc, inst: push_adel ? 32'h0 : push_inst, adel: push_adel};
  assign full         = (count_q == CNT_W'(DEPTH));
  assign stored_valid = (count_q != '0);
  // A return is only kept when no flushed request is still owed to us.
  assign accept_ret   = data_ok & ~flush & (discard_q == '0);

`ifdef INST_BUF_BYPASS_EN
  assign bypass_hit = accept_ret & pop & ~stored_valid;
`else
  assign bypass_hit = 1'b0;
`endif

  assign pop_en  = pop & stored_valid & ~flush;
  assign push_en = accept_ret & ~bypass_hit;
  assign ovf     = push_en & full & ~pop_en;
  assign wr_en   = push_en & ~ovf;

  assign occupancy = SUM_W'(count_q) + SUM_W'(ost_q);
  assign can_issue = (occupancy < SUM_W'(DEPTH)) & (ost_q < OST_W'(OST_MAX)) & ~flush;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    rptr_d    = rptr_q;
    wptr_d    = wptr_q;
    count_d   = count_q;
    discard_d = discard_q;
    ovf_err_d = ovf_err_q | ovf;
    ost_d     = ost_q;

    // Outstanding count never goes below zero; stray returns are not ours to track.
    if (req_accept && !(data_ok && ost_q != '0)) begin
      ost_d = ost_q + 1'b1;
    end else if (!req_accept && data_ok && ost_q != '0) begin
      ost_d = ost_q - 1'b1;
    end

    if (flush) begin
      rptr_d    = '0;
      wptr_d    = '0;
      count_d   = '0;
      discard_d = (data_ok && ost_q != '0) ? ost_q - 1'b1 : ost_q;
    end else begin
      if (wr_en)  wptr_d = wptr_q + 1'b1;
      if (pop_en) rptr_d = rptr_q + 1'b1;
      if (wr_en && !pop_en)      count_d = count_q + 1'b1;
      else if (!wr_en && pop_en) count_d = count_q - 1'b1;
      if (data_ok && discard_q != '0) discard_d = discard_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rptr_q    <= '0;
      wptr_q    <= '0;
      count_q   <= '0;
      ost_q     <= '0;
      discard_q <= '0;
      ovf_err_q <= 1'b0;
    end else begin
      rptr_q    <= rptr_d;
      wptr_q    <= wptr_d;
      count_q   <= count_d;
      ost_q     <= ost_d;
      discard_q <= discard_d;
      ovf_err_q <= ovf_err_d;
    end
  end

  // NOTE: storage has no reset; count_q gates every read, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wptr_q] <= push_entry;
  end

  always_comb begin
    out_entry = '0;
    if (bypass_hit)        out_entry = push_entry;
    else if (stored_valid) out_entry = mem_q[rptr_q];
  end

  assign out_valid = stored_valid | bypass_hit;
  assign out_pc    = out_entry.pc;
  assign out_inst  = out_entry.inst;
  assign out_adel  = out_entry.adel;
  assign out_op    = out_inst[31:26];
  assign out_rs    = out_inst[25:21];
  assign out_rt    = out_inst[20:16];
  assign out_funct = out_inst[5:0];

endmodule

// File: tb/tb_inst_fetch_buffer.sv
// Directed self-checking bench for inst_fetch_buffer (DEPTH=4, OST_MAX=3); expectations adapt to INST_BUF_BYPASS_EN.
module tb_inst_fetch_buffer;

  logic        clk = 1'b0;
  logic        resetn, flush, req_accept, data_ok, push_adel, pop;
  logic [31:0] push_pc, push_inst;
  logic        can_issue, out_valid, out_adel;
  logic [31:0] out_pc, out_inst;
  logic [5:0]  out_op, out_funct;
  logic [4:0]  out_rs, out_rt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  inst_fetch_buffer #(.DEPTH(4), .OST_MAX(3)) dut (
    .clk(clk), .resetn(resetn), .flush(flush), .req_accept(req_accept),
    .data_ok(data_ok), .push_pc(push_pc), .push_inst(push_inst),
    .push_adel(push_adel), .can_issue(can_issue), .pop(pop),
    .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst),
    .out_adel(out_adel), .out_op(out_op), .out_rs(out_rs), .out_rt(out_rt),
    .out_funct(out_funct)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    flush = 0; req_accept = 0; data_ok = 0; pop = 0;
    push_pc = '0; push_inst = '0; push_adel = 0;
  endtask

  // Drive inputs for one cycle starting just after a rising edge.
  task automatic drive(input logic dok, input logic [31:0] pc, input logic [31:0] inst,
                       input logic adel, input logic p, input logic ra, input logic fl);
    data_ok = dok; push_pc = pc; push_inst = inst; push_adel = adel;
    pop = p; req_accept = ra; flush = fl;
    #1;
  endtask

  task automatic tick();
    @(posedge clk); #1;
    idle();
    #1;
  endtask

  task automatic do_reset();
    idle();
    resetn = 0;
    @(posedge clk); #1;
    resetn = 1;
    #1;
  endtask

  initial begin
    idle();
    resetn = 0;
    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_pc", out_pc, 0);
    check("rst_out_inst", out_inst, 0);
    check("rst_count", dut.count_q, 0);
    @(posedge clk); #1; resetn = 1; #1;
    check("rst_can_issue", can_issue, 1);

    // Three pushes, no pop
    drive(1, 32'hBFC00000, 32'h24010001, 0, 0, 0, 0); tick();
    check("p1_no_bypass_latency", out_pc, 32'hBFC00000);
    drive(1, 32'hBFC00004, 32'h24020002, 0, 0, 0, 0); tick();
    drive(1, 32'hBFC00008, 32'h24030003, 0, 0, 0, 0); tick();
    check("p3_count", dut.count_q, 3);
    check("p3_out_pc", out_pc, 32'hBFC00000);
    check("p3_out_op", out_op, 6'b001001);
    check("p3_out_rt", out_rt, 1);
    check("p3_out_rs", out_rs, 0);
    drive(0, 0, 0, 0, 1, 0, 0); tick();
    check("pop1_out_pc", out_pc, 32'hBFC00004);
    check("pop1_out_rt", out_rt, 2);
    drive(0, 0, 0, 0, 1, 0, 0); tick();
    drive(0, 0, 0, 0, 1, 0, 0); tick();
    check("pop3_out_valid", out_valid, 0);
    check("pop3_out_inst", out_inst, 0);
    check("pop3_out_pc", out_pc, 0);
    drive(0, 0, 0, 0, 1, 0, 0); tick();
    check("pop_empty_ignored_count", dut.count_q, 0);

    // Fill to full, simultaneous push/pop, then overflow
    do_reset();
    check("reset_mid_count", dut.count_q, 0);
    check("reset_mid_wptr", dut.wptr_q, 0);
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'h100 + 32'(i * 4), 32'h1000 + 32'(i), 0, 0, 0, 0); tick();
    end
    check("full_count", dut.count_q, 4);
    check("full_can_issue", can_issue, 0);
    drive(1, 32'h110, 32'h1004, 0, 1, 0, 0); tick();
    check("pp_full_count", dut.count_q, 4);
    check("pp_full_rptr", dut.rptr_q, 1);
    check("pp_full_wptr", dut.wptr_q, 1);
    check("pp_full_ovf", dut.ovf_err_q, 0);
    check("pp_full_head", out_pc, 32'h104);
    drive(1, 32'h999, 32'h9999, 0, 0, 0, 0); tick();
    check("ovf_flag", dut.ovf_err_q, 1);
    check("ovf_count", dut.count_q, 4);
    check("ovf_wptr", dut.wptr_q, 1);
    check("ovf_head", out_pc, 32'h104);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 1, 0, 0); tick();
    end
    check("ovf_tail_intact", out_pc, 32'h110);

    // Flush with three requests outstanding
    do_reset();
    drive(1, 32'h200, 32'h2000, 0, 0, 0, 0); tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 1, 0); tick();
    end
    check("ost3", dut.ost_q, 3);
    check("ost3_can_issue", can_issue, 0);
    check("pre_flush_valid", out_valid, 1);
    drive(0, 0, 0, 0, 1, 0, 1);
    check("flush_can_issue", can_issue, 0);
    tick();
    check("flush_out_valid", out_valid, 0);
    check("flush_discard", dut.discard_q, 3);
    check("flush_count", dut.count_q, 0);
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'hDEAD0000 + 32'(i), 32'h11111111, 0, 0, 0, 0); tick();
      check("discard_out_valid", out_valid, 0);
    end
    check("discard_done", dut.discard_q, 0);
    check("discard_ost", dut.ost_q, 0);
    drive(0, 0, 0, 0, 0, 1, 0); tick();
    drive(1, 32'hBFC00380, 32'h3C1DBFC0, 0, 0, 0, 0); tick();
    check("post_discard_valid", out_valid, 1);
    check("post_discard_pc", out_pc, 32'hBFC00380);

    // Flush + data_ok + req_accept together with ost=2
    do_reset();
    drive(0, 0, 0, 0, 0, 1, 0); tick();
    drive(0, 0, 0, 0, 0, 1, 0); tick();
    drive(1, 32'hAAA0, 32'h12345678, 0, 0, 1, 1); tick();
    check("fdr_discard", dut.discard_q, 1);
    check("fdr_ost", dut.ost_q, 2);
    check("fdr_out_valid", out_valid, 0);
    drive(1, 32'hAAA4, 32'h22222222, 0, 0, 0, 0); tick();
    check("fdr_drop_valid", out_valid, 0);
    check("fdr_drop_ost", dut.ost_q, 1);
    drive(1, 32'hAAA8, 32'h33333333, 0, 0, 0, 0); tick();
    check("fdr_keep_valid", out_valid, 1);
    check("fdr_keep_pc", out_pc, 32'hAAA8);

    // Fetch address error forces the word to zero
    drive(1, 32'hBFC00010, 32'h8C220000, 1, 1, 0, 0); tick();
    check("adel_out_adel", out_adel, 1);
    check("adel_out_inst", out_inst, 0);
    check("adel_out_funct", out_funct, 0);
    check("adel_out_pc", out_pc, 32'hBFC00010);
    drive(0, 0, 0, 0, 1, 0, 0); tick();
    check("adel_popped", out_valid, 0);

    // Empty queue, data_ok and pop together
    drive(1, 32'h300, 32'h00851020, 0, 1, 0, 0);
`ifdef INST_BUF_BYPASS_EN
    check("byp_same_valid", out_valid, 1);
    check("byp_same_funct", out_funct, 6'b100000);
    check("byp_same_pc", out_pc, 32'h300);
    tick();
    check("byp_next_count", dut.count_q, 0);
    check("byp_next_valid", out_valid, 0);
`else
    check("nobyp_same_valid", out_valid, 0);
    check("nobyp_same_funct", out_funct, 0);
    tick();
    check("nobyp_next_valid", out_valid, 1);
    check("nobyp_next_funct", out_funct, 6'b100000);
    check("nobyp_next_count", dut.count_q, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
